// File: rtl/spi_loader_pkg.sv
// ---------------------------------------------------------------------------
// spi_loader_pkg : shared commands, AHB encodings and FSM states for spi_loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_loader_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_DONE      = 8'h0F;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_CMD   = 3'd1,
    RX_ADDR  = 3'd2,
    RX_DATA  = 3'd3,
    RX_DRAIN = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_ADDR = 2'd1,
    B_DATA = 2'd2
  } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge : multi-flop synchronizer with rise/fall detect on synced level
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sync_edge
  import spi_loader_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1];
  assign rise    = w_level & ~r_prev;
  assign fall    = ~w_level & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_loader.sv
// ---------------------------------------------------------------------------
// spi_loader : SPI mode-0 slave turning write frames into AHB-lite word writes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_loader
  import spi_loader_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_WRITE   = spi_loader_pkg::CMD_WRITE,
  parameter logic [7:0]  CMD_DONE    = spi_loader_pkg::CMD_DONE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic [31:0] spi_haddr,
  output logic [31:0] spi_hwdata,
  output logic        spi_hwrite,
  output logic [1:0]  spi_htrans,
  output logic [2:0]  spi_hsize,
  output logic [2:0]  spi_hburst,
  output logic [3:0]  spi_hprot,
  output logic        spi_hmastlock,
  input  logic        spi_hready,
  input  logic        spi_hresp,
  output logic        spi_change,
  output logic        busy
);

  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic                   w_mosi;
  logic                   w_csn;

  rx_state_e   r_rx_state;
  bus_state_e  r_bus_state;
  logic [4:0]  r_bit_cnt;
  logic        r_bit;
  logic [31:0] r_addr_sr;
  logic [31:0] r_data_sr;
  logic [7:0]  r_tx_sr;
  logic        r_post;
  logic        r_change;
  logic        r_overrun;
  logic        r_err;

  logic [31:0] r_haddr;
  logic [31:0] r_hwdata;
  logic [31:0] r_wdata;
  logic        r_hwrite;
  logic [1:0]  r_htrans;
  logic        r_busy;

  logic [31:0] w_shift_data;
  logic [7:0]  w_cmd;
  logic        w_bus_free;
  logic        w_err_set;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sck_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sck),
    .rise  (w_sck_rise),
    .fall  (w_sck_fall)
  );

  // cs_n resets to the deasserted level so reset release never looks like a frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mosi_sync <= '0;
      r_csn_sync  <= '1;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], cs_n};
    end
  end

  assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
  assign w_csn        = r_csn_sync[SYNC_STAGES-1];
  assign w_shift_data = {r_data_sr[30:0], r_bit};
  assign w_cmd        = w_shift_data[7:0];
  assign w_bus_free   = (r_bus_state == B_IDLE) && !r_post;
  assign w_err_set    = (r_bus_state == B_DATA) && spi_hready && spi_hresp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_bit_cnt  <= 5'd0;
      r_bit      <= 1'b0;
      r_addr_sr  <= 32'd0;
      r_data_sr  <= 32'd0;
      r_tx_sr    <= 8'd0;
      r_post     <= 1'b0;
      r_change   <= 1'b0;
      r_overrun  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_post   <= 1'b0;
      r_change <= 1'b0;
      if (w_err_set) r_err <= 1'b1;
      if (w_sck_rise) r_bit <= w_mosi;

      if (w_csn) begin
        r_rx_state <= RX_IDLE;
        r_tx_sr    <= 8'd0;
      end else begin
        case (r_rx_state)
          RX_IDLE: begin
            r_rx_state <= RX_CMD;
            r_bit_cnt  <= 5'd0;
            r_tx_sr    <= {5'b0, r_err, r_overrun, r_busy};
          end
          RX_CMD: if (w_sck_fall) begin
            r_data_sr <= w_shift_data;
            r_tx_sr   <= {r_tx_sr[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              // status byte has been read out: clear sticky flags, keeping a same-cycle error
              r_bit_cnt <= 5'd0;
              r_tx_sr   <= 8'd0;
              r_overrun <= 1'b0;
              r_err     <= w_err_set;
              if (w_cmd == CMD_WRITE) begin
                r_rx_state <= RX_ADDR;
              end else begin
                r_change   <= (w_cmd == CMD_DONE);
                r_rx_state <= RX_DRAIN;
              end
            end
          end
          RX_ADDR: if (w_sck_fall) begin
            r_addr_sr <= {r_addr_sr[30:0], r_bit};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd31) r_rx_state <= RX_DATA;
          end
          RX_DATA: if (w_sck_fall) begin
            r_data_sr <= w_shift_data;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd31) begin
              if (w_bus_free) r_post    <= 1'b1;
              else            r_overrun <= 1'b1;
              r_rx_state <= RX_DRAIN;
            end
          end
          RX_DRAIN: ;
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_state <= B_IDLE;
      r_haddr     <= 32'd0;
      r_hwdata    <= 32'd0;
      r_wdata     <= 32'd0;
      r_hwrite    <= 1'b0;
      r_htrans    <= HTRANS_IDLE;
      r_busy      <= 1'b0;
    end else begin
      case (r_bus_state)
        B_IDLE: if (r_post) begin
          r_haddr     <= r_addr_sr;
          r_wdata     <= r_data_sr;
          r_hwrite    <= 1'b1;
          r_htrans    <= HTRANS_NONSEQ;
          r_busy      <= 1'b1;
          r_bus_state <= B_ADDR;
        end
        B_ADDR: if (spi_hready) begin
          r_htrans    <= HTRANS_IDLE;
          r_hwrite    <= 1'b0;
          r_hwdata    <= r_wdata;
          r_bus_state <= B_DATA;
        end
        B_DATA: if (spi_hready) begin
          r_busy      <= 1'b0;
          r_bus_state <= B_IDLE;
        end
        default: r_bus_state <= B_IDLE;
      endcase
    end
  end

  assign miso          = r_tx_sr[7];
  assign spi_haddr     = r_haddr;
  assign spi_hwdata    = r_hwdata;
  assign spi_hwrite    = r_hwrite;
  assign spi_htrans    = r_htrans;
  assign spi_hsize     = HSIZE_WORD;
  assign spi_hburst    = HBURST_SINGLE;
  assign spi_hprot     = HPROT_DATA;
  assign spi_hmastlock = 1'b0;
  assign spi_change    = r_change;
  assign busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_spi_loader.sv
// ---------------------------------------------------------------------------
// tb_spi_loader : directed bench for spi_loader (frames, wait states, overrun)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_spi_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic        miso;
  logic [31:0] spi_haddr;
  logic [31:0] spi_hwdata;
  logic        spi_hwrite;
  logic [1:0]  spi_htrans;
  logic [2:0]  spi_hsize;
  logic [2:0]  spi_hburst;
  logic [3:0]  spi_hprot;
  logic        spi_hmastlock;
  logic        spi_hready = 1'b1;
  logic        spi_hresp = 1'b0;
  logic        spi_change;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int active_cycles = 0;
  int change_cycles = 0;

  spi_loader #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .sck           (sck),
    .mosi          (mosi),
    .cs_n          (cs_n),
    .miso          (miso),
    .spi_haddr     (spi_haddr),
    .spi_hwdata    (spi_hwdata),
    .spi_hwrite    (spi_hwrite),
    .spi_htrans    (spi_htrans),
    .spi_hsize     (spi_hsize),
    .spi_hburst    (spi_hburst),
    .spi_hprot     (spi_hprot),
    .spi_hmastlock (spi_hmastlock),
    .spi_hready    (spi_hready),
    .spi_hresp     (spi_hresp),
    .spi_change    (spi_change),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spi_htrans !== 2'b00) active_cycles++;
    if (spi_change !== 1'b0) change_cycles++;
  end

  task automatic spi_begin();
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // MSB first; miso sampled just before each rising sck
  task automatic spi_bits(input int n, input logic [31:0] val, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = val[i];
      repeat (4) @(negedge clk);
      rx  = {rx[6:0], miso};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic write_frame(input logic [31:0] addr, input logic [31:0] data,
                             output logic [7:0] status);
    logic [7:0] dummy;
    spi_begin();
    spi_bits(8, 32'h02, status);
    spi_bits(32, addr, dummy);
    spi_bits(32, data, dummy);
  endtask

  task automatic status_frame(input logic [7:0] cmd, output logic [7:0] status);
    spi_begin();
    spi_bits(8, {24'd0, cmd}, status);
    spi_end();
  endtask

  task automatic wait_nonseq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (spi_htrans === 2'b10) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({spi_htrans, spi_hwrite, busy, miso, spi_change} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got htrans=%b hwrite=%b busy=%b miso=%b change=%b, want all 0",
               spi_htrans, spi_hwrite, busy, miso, spi_change);
    end
    checks++;
    if ({spi_haddr, spi_hwdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_bus: got haddr=%h hwdata=%h, want 0", spi_haddr, spi_hwdata);
    end
    checks++;
    if ({spi_hsize, spi_hburst, spi_hprot, spi_hmastlock} !== {3'b010, 3'b000, 4'b0011, 1'b0}) begin
      errors++;
      $display("FAIL const_outputs: got hsize=%b hburst=%b hprot=%b hmastlock=%b, want 010 000 0011 0",
               spi_hsize, spi_hburst, spi_hprot, spi_hmastlock);
    end
  endtask

  task automatic test_write();
    logic [7:0] st;
    bit ok;
    int a0;
    spi_hready = 1'b1;
    a0 = active_cycles;
    write_frame(32'h0000_4010, 32'hDEAD_BEEF, st);
    checks++;
    if (st !== 8'h00) begin
      errors++; $display("FAIL write_status: got %h want 00", st);
    end
    wait_nonseq(ok);
    checks++;
    if (!ok || spi_haddr !== 32'h0000_4010 || spi_hwrite !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_addr_phase: got seen=%0d haddr=%h hwrite=%b busy=%b want 1 00004010 1 1",
               ok, spi_haddr, spi_hwrite, busy);
    end
    @(negedge clk);
    checks++;
    if (spi_htrans !== 2'b00 || spi_hwrite !== 1'b0 || spi_hwdata !== 32'hDEAD_BEEF || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_data_phase: got htrans=%b hwrite=%b hwdata=%h busy=%b want 00 0 deadbeef 1",
               spi_htrans, spi_hwrite, spi_hwdata, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL write_busy_len: got busy=%b on 3rd cycle want 0", busy);
    end
    spi_end();
    checks++;
    if (active_cycles - a0 !== 1) begin
      errors++; $display("FAIL write_nonseq_count: got %0d want 1", active_cycles - a0);
    end
  endtask

  task automatic test_wait_states();
    logic [7:0] st;
    bit ok;
    int stable;
    spi_hready = 1'b1;
    write_frame(32'h0000_4010, 32'hDEAD_BEEF, st);
    wait_nonseq(ok);
    stable = 0;
    @(negedge clk);
    if (spi_hwdata === 32'hDEAD_BEEF && busy === 1'b1) stable++;
    spi_hready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (spi_hwdata === 32'hDEAD_BEEF && busy === 1'b1) stable++;
    end
    spi_hready = 1'b1;
    checks++;
    if (!ok || stable !== 4) begin
      errors++; $display("FAIL wait_hold: got seen=%0d stable_cycles=%0d want 1 4", ok, stable);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wait_release: got busy=%b after hready want 0", busy);
    end
    spi_end();
  endtask

  task automatic test_done();
    logic [7:0] st;
    int a0, c0;
    a0 = active_cycles;
    c0 = change_cycles;
    status_frame(8'h0F, st);
    checks++;
    if (change_cycles - c0 !== 1) begin
      errors++; $display("FAIL done_pulse1: got %0d high cycles want 1", change_cycles - c0);
    end
    status_frame(8'h0F, st);
    checks++;
    if (change_cycles - c0 !== 2) begin
      errors++; $display("FAIL done_pulse2: got %0d total high cycles want 2", change_cycles - c0);
    end
    checks++;
    if (active_cycles !== a0) begin
      errors++; $display("FAIL done_no_ahb: got %0d active cycles want 0", active_cycles - a0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] st;
    bit ok;
    int a0;
    a0 = active_cycles;
    spi_begin();
    spi_bits(8, 32'h02, st);
    spi_bits(20, 32'h000A_BCDE, st);
    spi_end();
    repeat (10) @(negedge clk);
    checks++;
    if (active_cycles !== a0) begin
      errors++; $display("FAIL abort_no_ahb: got %0d active cycles want 0", active_cycles - a0);
    end
    write_frame(32'h0000_8003, 32'h0000_0001, st);
    wait_nonseq(ok);
    checks++;
    if (!ok || spi_haddr !== 32'h0000_8003) begin
      errors++; $display("FAIL abort_next_addr: got seen=%0d haddr=%h want 1 00008003", ok, spi_haddr);
    end
    @(negedge clk);
    checks++;
    if (spi_hwdata !== 32'h0000_0001) begin
      errors++; $display("FAIL abort_next_data: got %h want 00000001", spi_hwdata);
    end
    spi_end();
  endtask

  task automatic test_back_to_back();
    logic [7:0] st;
    bit ok;
    int a0;
    spi_hready = 1'b0;
    a0 = active_cycles;
    write_frame(32'h0000_4010, 32'h1111_1111, st);
    wait_nonseq(ok);
    spi_end();
    write_frame(32'h0000_8000, 32'h2222_2222, st);
    spi_end();
    checks++;
    if (!ok || st !== 8'h01) begin
      errors++; $display("FAIL b2b_status_busy: got seen=%0d status=%h want 1 01", ok, st);
    end
    status_frame(8'h00, st);
    checks++;
    if (st !== 8'h03) begin
      errors++; $display("FAIL b2b_overrun: got status=%h want 03", st);
    end
    status_frame(8'h00, st);
    checks++;
    if (st !== 8'h01) begin
      errors++; $display("FAIL b2b_cleared: got status=%h want 01", st);
    end
    spi_hready = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || spi_haddr !== 32'h0000_4010 || spi_hwdata !== 32'h1111_1111) begin
      errors++;
      $display("FAIL b2b_first_kept: got busy=%b haddr=%h hwdata=%h want 0 00004010 11111111",
               busy, spi_haddr, spi_hwdata);
    end
    status_frame(8'h00, st);
    checks++;
    if (st !== 8'h00 || active_cycles - a0 < 1) begin
      errors++; $display("FAIL b2b_idle_status: got status=%h want 00", st);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] st;
    bit ok;
    int c0;
    spi_hready = 1'b0;
    c0 = change_cycles;
    write_frame(32'h0000_4010, 32'h0000_0055, st);
    wait_nonseq(ok);
    reset = 1'b1;
    cs_n  = 1'b1;
    #1;
    checks++;
    if (!ok || spi_htrans !== 2'b00 || busy !== 1'b0 || spi_hwrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_bus: got seen=%0d htrans=%b busy=%b hwrite=%b want 1 00 0 0",
               ok, spi_htrans, busy, spi_hwrite);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    spi_hready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (change_cycles !== c0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got change_cycles=%0d busy=%b want 0 0", change_cycles - c0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_states();
    test_done();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
